// File: rtl/mips_pkg.sv
// mips_pkg: control-bit positions and word width shared by decode, execute and memory stages.
package mips_pkg;
    localparam int WORD_W      = 32;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
endpackage

// File: rtl/data_memory.sv
// data_memory: word-addressed single-port RAM with registered read-before-write output.
module data_memory
    import mips_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata_q
);
    logic [WORD_W-1:0] mem [DEPTH];

    // The read samples the array before this edge's write lands, so a
    // simultaneous read+write returns the old word.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata_q <= re ? mem[addr] : '0;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage -- data-memory access, branch resolution and MEM/WB latch.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        wb_ctlout,
    input  logic [2:0]        m_ctlout,
    input  logic [WORD_W-1:0] add_result,
    input  logic [WORD_W-1:0] alu_result,
    input  logic [WORD_W-1:0] rdata2out,
    input  logic              zero,
    input  logic [4:0]        five_bit_muxout,
    output logic              pcsrc,
    output logic [WORD_W-1:0] branch_target,
    output logic [1:0]        wb_ctl_q,
    output logic [WORD_W-1:0] read_data_q,
    output logic [WORD_W-1:0] alu_result_q,
    output logic [4:0]        write_reg_q
);
    logic unused_addr_bits;
    assign unused_addr_bits = ^{alu_result[WORD_W-1:AW+2], alu_result[1:0]};

    assign pcsrc         = m_ctlout[M_BRANCH] & zero & ~reset;
    assign branch_target = add_result;

    // Gating read-enable with reset clears read_data_q through the RAM's re=0 path.
    data_memory #(.DEPTH(DEPTH), .AW(AW)) u_dmem (
        .clk    (clk),
        .we     (m_ctlout[M_MEMWRITE] & ~reset),
        .re     (m_ctlout[M_MEMREAD] & ~reset),
        .addr   (alu_result[AW+1:2]),
        .wdata  (rdata2out),
        .rdata_q(read_data_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ctl_q     <= '0;
            alu_result_q <= '0;
            write_reg_q  <= '0;
        end else begin
            wb_ctl_q     <= wb_ctlout;
            alu_result_q <= alu_result;
            write_reg_q  <= five_bit_muxout;
        end
    end
endmodule
